// File: rtl/coin_key_filter_if.sv
// Coin key bundle for the vending front end: raw active-low keys in,
// one-cycle confirmed-press pulses out.
interface coin_key_filter_if;
    logic key_yuan_n;
    logic key_jiao_n;
    logic in_yuan;
    logic in_jiao;

    modport master (
        output key_yuan_n,
        output key_jiao_n,
        input  in_yuan,
        input  in_jiao
    );

    modport slave (
        input  key_yuan_n,
        input  key_jiao_n,
        output in_yuan,
        output in_jiao
    );
endinterface

// File: rtl/coin_key_filter.sv
// Two independent debounce channels (1 yuan, 5 jiao), each emitting one
// single-cycle pulse per confirmed press.
module coin_key_filter #(
    parameter int CNT_MAX = 999_999,
    parameter int CNT_W   = 20
) (
    input  logic               clk,
    input  logic               rst,
    coin_key_filter_if.slave   keys
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic             raw_n;
        logic             sync1;
        logic             s;
        state_t           state;
        state_t           state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             pulse;
        logic             pulse_next;

        if (ch == 0) begin : g_yuan
            assign raw_n        = keys.key_yuan_n;
            assign keys.in_yuan = pulse;
        end else begin : g_jiao
            assign raw_n        = keys.key_jiao_n;
            assign keys.in_jiao = pulse;
        end

        // Synchroniser resets to the released level so a key held through
        // reset is seen as a fresh press and fully debounced from IDLE.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1 <= 1'b1;
                s     <= 1'b1;
            end else begin
                sync1 <= raw_n;
                s     <= sync1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
                pulse <= 1'b0;
            end else begin
                state <= state_next;
                cnt   <= cnt_next;
                pulse <= pulse_next;
            end
        end

        // Counter clears on every state change and while waiting in a stable
        // state, so it only runs while a level is being confirmed.
        always_comb begin
            state_next = state;
            cnt_next   = '0;
            pulse_next = 1'b0;
            case (state)
                IDLE: begin
                    if (!s) state_next = PRESS_WAIT;
                end
                PRESS_WAIT: begin
                    if (s) begin
                        state_next = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_next = PRESSED;
                        pulse_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (s) state_next = RELEASE_WAIT;
                end
                RELEASE_WAIT: begin
                    if (!s) begin
                        state_next = PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_key_filter.sv
// Scoreboard bench for coin_key_filter with CNT_MAX=4: stimulus queues the
// expected pulse edge, a negedge monitor pops and compares on every pulse.
module tb_coin_key_filter;

    localparam int CNT_MAX = 4;
    localparam int CNT_W   = 3;
    localparam int LAT     = CNT_MAX + 3;

    typedef struct {
        int         cyc;
        logic [1:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_count = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expected_q[$];

    coin_key_filter_if keys ();

    coin_key_filter #(
        .CNT_MAX(CNT_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .keys(keys.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_count <= edge_count + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edge_count);
        end
    endtask

    // Drive both keys just after the next rising edge; e0 is the first edge
    // that samples the new levels.
    task automatic applyStimulus(input logic yuan_n, input logic jiao_n, output int e0);
        @(posedge clk);
        #2;
        keys.key_yuan_n = yuan_n;
        keys.key_jiao_n = jiao_n;
        e0 = edge_count + 1;
    endtask

    task automatic hold_for(input int n);
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic expect_pulse(input int cyc, input logic yuan, input logic jiao);
        exp_t e;
        e.cyc = cyc;
        e.val = {yuan, jiao};
        expected_q.push_back(e);
    endtask

    // Every high output cycle must match the head of the scoreboard, which
    // also catches stretched or spurious pulses.
    always @(negedge clk) begin : monitor
        exp_t entry;
        if (!rst && (keys.in_yuan || keys.in_jiao)) begin
            if (expected_q.size() == 0) begin
                checkOutput("unexpected_pulse", int'({keys.in_yuan, keys.in_jiao}), 0);
            end else begin
                entry = expected_q.pop_front();
                checkOutput("pulse_edge", edge_count, entry.cyc);
                checkOutput("pulse_value", int'({keys.in_yuan, keys.in_jiao}), int'(entry.val));
            end
        end
    end

    initial begin : stimulus
        int e0;
        int e1;
        int r0;

        keys.key_yuan_n = 1'b1;
        keys.key_jiao_n = 1'b1;
        #3;
        checkOutput("reset_in_yuan", int'(keys.in_yuan), 0);
        checkOutput("reset_in_jiao", int'(keys.in_jiao), 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);

        // Clean yuan press, 20 cycles.
        applyStimulus(1'b0, 1'b1, e0);
        expect_pulse(e0 + LAT, 1'b1, 1'b0);
        hold_for(20);
        applyStimulus(1'b1, 1'b1, e0);
        hold_for(12);

        // Jiao press bounce, then stable low.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, e0);
            hold_for(2);
            applyStimulus(1'b1, 1'b1, e0);
            hold_for(2);
        end
        applyStimulus(1'b1, 1'b0, e0);
        expect_pulse(e0 + LAT, 1'b0, 1'b1);
        hold_for(20);
        applyStimulus(1'b1, 1'b1, e0);
        hold_for(12);

        // Long hold with release chatter; re-press at the earliest edge IDLE allows.
        applyStimulus(1'b0, 1'b1, e0);
        expect_pulse(e0 + LAT, 1'b1, 1'b0);
        hold_for(50);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, e0);
            hold_for(2);
            applyStimulus(1'b0, 1'b1, e0);
            hold_for(2);
        end
        applyStimulus(1'b1, 1'b1, r0);
        hold_for(6);
        applyStimulus(1'b0, 1'b1, e1);
        expect_pulse(r0 + 6 + LAT, 1'b1, 1'b0);
        hold_for(10);
        applyStimulus(1'b1, 1'b1, e0);
        hold_for(12);

        // Simultaneous press on both keys.
        applyStimulus(1'b0, 1'b0, e0);
        expect_pulse(e0 + LAT, 1'b1, 1'b1);
        hold_for(20);
        applyStimulus(1'b1, 1'b1, e0);
        hold_for(12);

        // Reset across E4 with the key held; debounce restarts from E5.
        applyStimulus(1'b0, 1'b1, e0);
        expect_pulse(e0 + 5 + LAT, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_in_yuan", int'(keys.in_yuan), 0);
        checkOutput("midreset_in_jiao", int'(keys.in_jiao), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) @(posedge clk);
        applyStimulus(1'b1, 1'b1, e0);
        hold_for(12);

        // Back-to-back presses, 10 low / 10 high / 10 low.
        applyStimulus(1'b0, 1'b1, e0);
        expect_pulse(e0 + LAT, 1'b1, 1'b0);
        expect_pulse(e0 + 20 + LAT, 1'b1, 1'b0);
        hold_for(10);
        applyStimulus(1'b1, 1'b1, e1);
        hold_for(10);
        applyStimulus(1'b0, 1'b1, e1);
        hold_for(10);
        applyStimulus(1'b1, 1'b1, e1);
        hold_for(15);

        checkOutput("pulses_outstanding", expected_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
